// File: rtl/btn_event_arbiter_pkg.sv
// Shared types and defaults for the button event arbiter.
// Holds the arbiter FSM states, the default timing constants and the evt_id width helper.
package vga_input_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 250000;
  localparam int DEF_SYNC_STAGES     = 2;

  // A single input still needs a one-bit id port.
  function automatic int calc_id_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_event_arbiter_if.sv
// Valid/ready event port carrying the index of a pressed button.
interface btn_event_arbiter_if #(
  parameter int ID_W = 2
) ();

  logic            evt_valid;
  logic            evt_ready;
  logic [ID_W-1:0] evt_id;

  modport master (
    output evt_valid,
    output evt_id,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_id,
    output evt_ready
  );

endinterface

// File: rtl/btn_event_arbiter_debounce.sv
// One button channel: synchroniser, stable-count debouncer and rising-edge pulse.
module btn_debounce
  import vga_input_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   w_s;

  assign w_s   = r_sync[SYNC_STAGES-1];
  assign level = r_level;
  assign rise  = r_rise;

  // Rise is registered alongside the level so both change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
      r_rise <= 1'b0;
      if (w_s == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= w_s;
        r_cnt   <= '0;
        r_rise  <= w_s;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/btn_event_arbiter.sv
// Debounced push-buttons serialised into one-shot press events by a round-robin scheduler.
module btn_event_arbiter
  import vga_input_pkg::*;
#(
  parameter int N_IN            = 4,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_IN-1:0]     btn_raw,
  btn_event_arbiter_if.master evt,
  output logic [N_IN-1:0]     btn_level,
  output logic [N_IN-1:0]     drop_pulse
);

  localparam int ID_W = calc_id_w(N_IN);

  logic [N_IN-1:0]   w_level;
  logic [N_IN-1:0]   w_rise;
  logic [N_IN-1:0]   w_req;
  logic [N_IN-1:0]   w_clr;
  logic [2*N_IN-1:0] w_req2;
  logic              w_hs;
  logic              w_found;
  logic [ID_W-1:0]   w_pick;

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              r_valid;
  logic              w_valid_nxt;
  logic [ID_W-1:0]   r_id;
  logic [ID_W-1:0]   w_id_nxt;
  logic [ID_W-1:0]   r_last;
  logic [N_IN-1:0]   r_pend;
  logic [N_IN-1:0]   r_drop;

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_btn
    btn_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_raw[gi]),
      .level (w_level[gi]),
      .rise  (w_rise[gi])
    );
  end

  assign btn_level     = w_level;
  assign drop_pulse    = r_drop;
  assign evt.evt_valid = r_valid;
  assign evt.evt_id    = r_id;

  assign w_hs  = r_valid & evt.evt_ready;
  // A rise this cycle is offered straight away instead of waiting for the pending flag.
  assign w_req = r_pend | w_rise;

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (w_hs && (int'(r_id) == i)) w_clr[i] = 1'b1;
    end
  end

  // Rotate so bit 0 is the input just after the last grant; lowest set bit wins.
  always_comb begin
    w_req2  = {w_req, w_req} >> (int'(r_last) + 1);
    w_found = 1'b0;
    w_pick  = '0;
    for (int j = N_IN - 1; j >= 0; j--) begin
      if (w_req2[j]) begin
        w_found = 1'b1;
        w_pick  = ID_W'((int'(r_last) + 1 + j) % N_IN);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_id_nxt    = r_id;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_valid_nxt = 1'b1;
          w_id_nxt    = w_pick;
          w_state_nxt = OFFER;
        end
      end
      OFFER: begin
        if (w_hs) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_id    <= '0;
      r_last  <= ID_W'(N_IN - 1);
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      r_id    <= w_id_nxt;
      if (w_hs) r_last <= r_id;
    end
  end

  // A new press on an input whose flag survives this cycle is reported as dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_drop <= '0;
    end else begin
      r_pend <= w_rise | (r_pend & ~w_clr);
      r_drop <= w_rise & r_pend & ~w_clr;
    end
  end

endmodule

// File: doc/btn_event_arbiter.md
Name: btn_event_arbiter

Overview:
Turns N_IN raw push-button inputs into a single stream of one-shot "button pressed" events for the VGA controller's mode/config logic.
- Per input: synchronise, debounce, detect the rising edge of the debounced level, latch it as a pending request.
- A round-robin scheduler serialises pending requests onto one valid/ready event port.
- Sits between the board I/O pins and the display-configuration logic.

Parameters:
N_IN, 4, number of button inputs (>=1)
SYNC_STAGES, 2, synchroniser flops per input (>=2)
DEBOUNCE_CYCLES, 250000, consecutive stable cycles needed to accept a level change (>=1; 10 ms at 25 MHz)
ID_W, $clog2(N_IN) (min 1), width of evt_id (derived, localparam)

Ports:
clk  in  1  system clock; all state on rising edge
rst_n  in  1  reset, asynchronous and active-low
btn_raw  in  N_IN  asynchronous raw button levels, 1 = pressed
evt_valid  out  1  event offered
evt_ready  in  1  consumer accepts event
evt_id  out  ID_W  index of the button whose press is offered
btn_level  out  N_IN  debounced level per input
drop_pulse  out  N_IN  1-cycle pulse: new press arrived while that input was already pending

Behaviour:
- Reset (rst_n=0, takes effect immediately): all sync flops, debounced levels, counters, pending flags, evt_valid, evt_id, drop_pulse clear to 0. last_grant is set to N_IN-1, so the first arbitration scans from input 0. FSM goes to IDLE. Pending events are lost.
- Sync: btn_raw[i] passes through SYNC_STAGES flops to give s[i].
- Debounce, per input, counter width $clog2(DEBOUNCE_CYCLES+1):
  - If s[i]==btn_level[i]: counter <= 0.
  - Else if counter==DEBOUNCE_CYCLES-1: btn_level[i] <= s[i], counter <= 0.
  - Else: counter++.
  - Any glitch shorter than DEBOUNCE_CYCLES synced cycles is ignored.
- Rise detect: rise[i]=1 on the same edge that btn_level[i] updates 0->1. Falling transitions generate no event.
- Pending, per input:
  - rise[i] sets pend[i].
  - A handshake on id i clears pend[i].
  - Simultaneous set and clear: set wins, so pend stays 1.
  - rise[i] while pend[i]=1 and not being cleared: drop_pulse[i]=1 for one cycle; pend stays 1.
- FSM states IDLE, OFFER:
  - IDLE: if any pend, pick the first set index scanning last_grant+1, last_grant+2, ... modulo N_IN. Register evt_id, set evt_valid=1, go to OFFER. If nothing is pending, stay in IDLE with evt_valid=0.
  - OFFER: evt_valid and evt_id are held stable until evt_valid&&evt_ready. On the handshake: clear pend[evt_id], last_grant <= evt_id, evt_valid <= 0, go to IDLE.
  - Maximum throughput is 1 event per 2 cycles.
- Latency: a btn_raw 0->1 change set up before edge k gives evt_valid=1 after edge k+SYNC_STAGES+DEBOUNCE_CYCLES, provided the FSM is idle and nothing is pending ahead of it.
- evt_id is a don't-care while evt_valid=0 but keeps its last value. With N_IN=1, evt_id=0 always.
- All outputs are registered; no combinational path from evt_ready to any output.

Decomposition:
- Package vga_input_pkg holds:
  - the FSM enum arb_state_t {IDLE, OFFER};
  - a function computing ID_W;
  - default constants DEF_DEBOUNCE_CYCLES and DEF_SYNC_STAGES.
- Sub-module btn_debounce, instantiated N_IN times:
  - contains the synchroniser, the debounce counter and the rise pulse;
  - ports clk, rst_n, raw, level, rise.
- The top level holds the pending flags, round-robin pick and FSM.

Test Plan:
All scenarios use N_IN=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
1. Reset: assert rst_n=0 mid-sim with btn_raw=4'hF -> evt_valid, btn_level and drop_pulse read 0 immediately; after release with no new edges, no event appears.
2. Single press: btn_raw[2] 0->1 before edge 0, held, evt_ready=1 -> btn_level[2]=1 after edge 5. evt_valid=1, evt_id=2 after edge 6, high exactly 1 cycle; no further event while held or on release.
3. Glitch: btn_raw[1] high for 3 cycles then low -> btn_level stays 4'h0, evt_valid never asserts.
4. Fairness: btn_raw 0,1,3 rise together, evt_ready=1 -> evt_id sequence 0,1,3 on alternating cycles. Then release all, re-press 0 and 1 together -> order 0,1 (last_grant=3 wraps to 0).
5. Backpressure and drop:
   - press 0 with evt_ready=0 -> evt_valid and evt_id=0 held stable for 30 cycles;
   - release and re-press 0 (debounced) during the hold -> drop_pulse[0]=1 for one cycle;
   - raise evt_ready -> exactly one event for id 0.
6. Reset mid-OFFER: evt_valid=1, evt_id=3, evt_ready=0, then pulse rst_n low -> evt_valid=0 immediately; after release no event for id 3 until a new debounced press.
